// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the downsampling-processor control unit
//   opcodes, FSM states, bus select codes, ALU ops and the decoded control word
package ctrl_pkg;
   localparam logic [3:0] OP_LDAC = 4'h1, OP_STAC = 4'h2, OP_MVAC = 4'h3, OP_MVR = 4'h4,
                          OP_ADD = 4'h5, OP_SUB = 4'h6, OP_SHR = 4'h7, OP_LDC = 4'h8,
                          OP_JPNZ = 4'h9, OP_JUMP = 4'hA, OP_END = 4'hF;
   localparam logic [2:0] ABUS_NONE = 3'd0, ABUS_AC = 3'd7;
   localparam logic [3:0] CBUS_NONE = 4'h0, CBUS_AC = 4'hB;
   localparam logic [2:0] ALU_PASS = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_SHR = 3'd3;
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC1, S_EXEC2, S_OPND1, S_OPND2, S_HALT
   } state_e;
   typedef enum logic [1:0] {MEM_NONE, MEM_DR, MEM_DW, MEM_CR} mem_e;
   typedef struct packed {
      logic [2:0] abus;
      logic [3:0] cbus;
      logic [2:0] alu;
      mem_e       mem;
      logic       jump;
      logic       cond;
      logic       halt;
   } ctrl_t;
endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational opcode/operand -> control word
//   op  : instruction opcode (instr[7:4])
//   r   : register operand (instr[2:0])
//   cw  : bus selects, ALU op, memory-op class, jump/conditional/end flags
module ctrl_decoder
   import ctrl_pkg::*;
(
   input  logic [3:0] op,
   input  logic [2:0] r,
   output ctrl_t      cw
);
   always_comb begin
      cw = '{abus: ABUS_NONE, cbus: CBUS_NONE, alu: ALU_PASS, mem: MEM_NONE,
             jump: 1'b0, cond: 1'b0, halt: 1'b0};
      case (op)
         OP_LDAC: cw.mem = MEM_DR;
         OP_STAC: cw.mem = MEM_DW;
         OP_LDC:  cw.mem = MEM_CR;
         OP_MVAC: begin
            cw.abus = ABUS_AC;
            cw.cbus = {1'b0, r};
         end
         OP_MVR, OP_ADD, OP_SUB, OP_SHR: begin
            cw.abus = r;
            cw.cbus = CBUS_AC;
            cw.alu  = op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : op == OP_SHR ? ALU_SHR : ALU_PASS;
         end
         OP_JPNZ: begin
            cw.jump = 1'b1;
            cw.cond = 1'b1;
         end
         OP_JUMP: cw.jump = 1'b1;
         OP_END:  cw.halt = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle fetch/decode/execute sequencer for the downsampling datapath
//   clock, rst        : clock, synchronous active-high reset
//   start             : begin at pc=0 (accepted only in IDLE)
//   instr, z_flag     : synchronous instruction memory data, ALU zero flag
//   pc                : instruction memory address
//   abus_en, cbus_en  : A-bus source / C-bus destination selects
//   alu_op            : ALU operation
//   dm_r, dm_wr, cm_r : accumulator load/store memory strobes
//   busy, done        : run status
module ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int PC_W = 8,
   parameter int IW   = 8
) (
   input  logic            clock,
   input  logic            rst,
   input  logic            start,
   input  logic [IW-1:0]   instr,
   input  logic            z_flag,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      abus_en,
   output logic [3:0]      cbus_en,
   output logic [2:0]      alu_op,
   output logic            dm_r,
   output logic            dm_wr,
   output logic            cm_r,
   output logic            busy,
   output logic            done
);
   state_e     state;
   logic [6:0] ir;
   ctrl_t      cw;
   ctrl_decoder u_dec (.op(ir[6:3]), .r(ir[2:0]), .cw(cw));
   // Strobes default to zero every cycle; DECODE loads them for EXEC1 and
   // EXEC1 re-holds only the memory strobe through EXEC2.
   always_ff @(posedge clock) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= '0;
         ir      <= '0;
         abus_en <= ABUS_NONE;
         cbus_en <= CBUS_NONE;
         alu_op  <= ALU_PASS;
         dm_r    <= 1'b0;
         dm_wr   <= 1'b0;
         cm_r    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         abus_en <= ABUS_NONE;
         cbus_en <= CBUS_NONE;
         alu_op  <= ALU_PASS;
         dm_r    <= 1'b0;
         dm_wr   <= 1'b0;
         cm_r    <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               state <= S_FETCH1;
               pc    <= '0;
               busy  <= 1'b1;
               done  <= 1'b0;
            end
            S_FETCH1: state <= S_FETCH2;
            S_FETCH2: begin
               ir    <= {instr[IW-1 -: 4], instr[2:0]};
               pc    <= pc + 1'b1;
               state <= S_DECODE;
            end
            S_DECODE: begin
               state <= cw.halt ? S_HALT : cw.jump ? S_OPND1 : S_EXEC1;
               if (!cw.halt && !cw.jump) begin
                  abus_en <= cw.abus;
                  cbus_en <= cw.cbus;
                  alu_op  <= cw.alu;
                  dm_r    <= cw.mem == MEM_DR;
                  dm_wr   <= cw.mem == MEM_DW;
                  cm_r    <= cw.mem == MEM_CR;
               end
            end
            S_EXEC1: if (cw.mem != MEM_NONE) begin
               state <= S_EXEC2;
               dm_r  <= dm_r;
               dm_wr <= dm_wr;
               cm_r  <= cm_r;
            end else state <= S_FETCH1;
            S_EXEC2: state <= S_FETCH1;
            S_OPND1: state <= S_OPND2;
            // pc still addresses the operand byte here, so fall-through is pc+1
            S_OPND2: begin
               state <= S_FETCH1;
               pc    <= (cw.cond && z_flag) ? pc + 1'b1 : PC_W'(instr);
            end
            S_HALT: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: self-checking bench for ctrl_unit against an instruction-level reference model
module tb_ctrl_unit;
   typedef struct packed {
      logic [7:0] pc;
      logic [2:0] ab;
      logic [3:0] cb;
      logic [2:0] alu;
      logic dmr;
      logic dmw;
      logic cmr;
      logic busy;
      logic done;
   } obs_t;
   typedef struct {
      logic [7:0] ins;
      logic [2:0] ab;
      logic [3:0] cb;
      logic [2:0] alu;
      logic dmr;
      logic dmw;
      logic cmr;
   } vec_t;
   logic clock = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic z_flag = 1'b0;
   logic [7:0] instr;
   logic [7:0] pc;
   logic [2:0] abus_en;
   logic [3:0] cbus_en;
   logic [2:0] alu_op;
   logic dm_r, dm_wr, cm_r, busy, done;
   logic [7:0] imem [256];
   bit zarr [4096];
   obs_t exp_q [$];
   int total = 0;
   int bad = 0;
   ctrl_unit #(.PC_W(8), .IW(8)) dut (
      .clock(clock), .rst(rst), .start(start), .instr(instr), .z_flag(z_flag),
      .pc(pc), .abus_en(abus_en), .cbus_en(cbus_en), .alu_op(alu_op),
      .dm_r(dm_r), .dm_wr(dm_wr), .cm_r(cm_r), .busy(busy), .done(done)
   );
   always #5 clock = ~clock;
   always @(posedge clock) instr <= imem[pc];
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   function automatic obs_t mk(input logic [7:0] p, input logic [2:0] ab, input logic [3:0] cb,
                               input logic [2:0] alu, input logic dmr, input logic dmw,
                               input logic cmr, input logic bsy, input logic dn);
      return {p, ab, cb, alu, dmr, dmw, cmr, bsy, dn};
   endfunction
   function automatic obs_t sample();
      return {pc, abus_en, cbus_en, alu_op, dm_r, dm_wr, cm_r, busy, done};
   endfunction
   function automatic string fmt(input obs_t o);
      return $sformatf("pc=%h ab=%0d cb=%h alu=%0d dmr=%b dmw=%b cmr=%b busy=%b done=%b",
                       o.pc, o.ab, o.cb, o.alu, o.dmr, o.dmw, o.cmr, o.busy, o.done);
   endfunction
   task automatic check(input string nm, input int idx, input obs_t got, input obs_t req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s[%0d] got {%s} required {%s}", nm, idx, fmt(got), fmt(req));
      end
   endtask
   task automatic excl(input string nm, input int idx);
      int n = int'(dm_r) + int'(dm_wr) + int'(cm_r);
      total++;
      if (n > 1 || (n == 1 && cbus_en != 4'h0)) begin
         bad++;
         $display("FAIL %s_excl[%0d] dmr=%b dmw=%b cmr=%b cbus=%h, required at most one strobe and cbus=0",
                  nm, idx, dm_r, dm_wr, cm_r, cbus_en);
      end
   endtask
   task automatic clear_mem();
      for (int i = 0; i < 256; i++) imem[i] = 8'hF0;
   endtask
   task automatic set_z(input bit v);
      for (int i = 0; i < 4096; i++) zarr[i] = v;
   endtask
   // Expands the program instruction by instruction into the per-cycle outputs
   // expected after the start edge, using the per-class latencies.
   task automatic model();
      logic [7:0] p = 8'h00;
      logic [7:0] ins;
      logic [3:0] op;
      obs_t o;
      bit taken;
      exp_q.delete();
      while (exp_q.size() < 4000) begin
         ins = imem[p];
         op = ins[7:4];
         o = mk(p, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         exp_q.push_back(o);
         exp_q.push_back(o);
         o.pc = 8'(p + 8'd1);
         exp_q.push_back(o);
         if (op == 4'hF) begin
            exp_q.push_back(o);
            o.busy = 1'b0;
            o.done = 1'b1;
            exp_q.push_back(o);
            break;
         end
         if (op == 4'h9 || op == 4'hA) begin
            exp_q.push_back(o);
            exp_q.push_back(o);
            taken = op == 4'hA || !zarr[exp_q.size() - 1];
            p = taken ? imem[8'(p + 8'd1)] : 8'(p + 8'd2);
            continue;
         end
         case (op)
            4'h1: o.dmr = 1'b1;
            4'h2: o.dmw = 1'b1;
            4'h8: o.cmr = 1'b1;
            4'h3: begin
               o.ab = 3'd7;
               o.cb = {1'b0, ins[2:0]};
            end
            4'h4, 4'h5, 4'h6, 4'h7: begin
               o.ab = ins[2:0];
               o.cb = 4'hB;
               o.alu = 3'(op - 4'd4);
            end
            default: ;
         endcase
         exp_q.push_back(o);
         if (o.dmr || o.dmw || o.cmr) exp_q.push_back(o);
         p = 8'(p + 8'd1);
      end
   endtask
   task automatic run_prog(input string nm, input bit poke);
      int n;
      model();
      n = exp_q.size();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         check(nm, k, sample(), exp_q[k]);
         excl(nm, k);
         z_flag = zarr[k];
         start = (poke && k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clock);
      end
      start = 1'b0;
   endtask
   initial begin
      vec_t vt [14];
      int w;
      int a;
      logic [3:0] rop;
      logic [7:0] rins;
      vt[0]  = '{8'h00, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{8'h10, 3'd0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0};
      vt[2]  = '{8'h20, 3'd0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0};
      vt[3]  = '{8'h35, 3'd7, 4'h5, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{8'h42, 3'd2, 4'hB, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{8'h53, 3'd3, 4'hB, 3'd1, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{8'h5B, 3'd3, 4'hB, 3'd1, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{8'h67, 3'd7, 4'hB, 3'd2, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{8'h74, 3'd4, 4'hB, 3'd3, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{8'h80, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1};
      vt[10] = '{8'hC0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[11] = '{8'hB3, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[12] = '{8'hD7, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0};
      vt[13] = '{8'hE1, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0};
      clear_mem();
      set_z(1'b0);
      repeat (3) @(negedge clock);
      check("reset", 0, sample(), '0);
      rst = 1'b0;
      foreach (vt[i]) begin
         clear_mem();
         imem[0] = vt[i].ins;
         @(negedge clock);
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
         repeat (3) @(negedge clock);
         check($sformatf("vec_%h", vt[i].ins), i, sample(),
               mk(8'h01, vt[i].ab, vt[i].cb, vt[i].alu, vt[i].dmr, vt[i].dmw, vt[i].cmr, 1'b1, 1'b0));
         w = 0;
         while (!done && w < 20) begin
            @(negedge clock);
            w++;
         end
         total++;
         if (!done) begin
            bad++;
            $display("FAIL vec_done[%0d] done=%b, required 1 within 20 cycles", i, done);
         end
      end
      clear_mem();
      imem[0] = 8'h42;
      imem[1] = 8'h51;
      run_prog("mvr_add_end", 1'b0);
      clear_mem();
      imem[0] = 8'h10;
      imem[1] = 8'h20;
      run_prog("ldac_stac", 1'b1);
      clear_mem();
      imem[0] = 8'h90;
      imem[1] = 8'h10;
      imem[2] = 8'h00;
      set_z(1'b0);
      run_prog("jpnz_taken", 1'b0);
      set_z(1'b1);
      run_prog("jpnz_fall", 1'b0);
      clear_mem();
      imem[0] = 8'h90;
      imem[1] = 8'hFF;
      imem[8'hFF] = 8'h00;
      set_z(1'b1);
      zarr[4] = 1'b0;
      run_prog("wrap_nop", 1'b0);
      imem[1] = 8'hFE;
      imem[8'hFE] = 8'hA0;
      imem[8'hFF] = 8'h00;
      run_prog("wrap_jump", 1'b1);
      imem[8'hFE] = 8'h90;
      imem[8'hFF] = 8'h55;
      run_prog("wrap_jpnz_fall", 1'b0);
      clear_mem();
      imem[0] = 8'h10;
      imem[1] = 8'h20;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      check("ldac_exec2", 0, sample(), mk(8'h01, 3'd0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      rst = 1'b1;
      @(negedge clock);
      check("mid_reset", 0, sample(), '0);
      rst = 1'b0;
      repeat (2) @(negedge clock);
      run_prog("after_reset", 1'b0);
      for (int t = 0; t < 25; t++) begin
         clear_mem();
         for (int i = 0; i < 4096; i++) zarr[i] = 1'($urandom_range(0, 1));
         a = 0;
         while (a < 40) begin
            rop = 4'($urandom_range(0, 14));
            rins = {rop, 4'($urandom_range(0, 15))};
            if (rop == 4'h9 || rop == 4'hA) begin
               if (a > 38) break;
               imem[a] = rins;
               imem[a + 1] = 8'($urandom_range(a + 2, 40));
               a += 2;
            end else begin
               imem[a] = rins;
               a++;
            end
         end
         run_prog($sformatf("rand%0d", t), 1'b1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
